// File: rtl/window_ctrl.sv
// window_ctrl: SPARC register-window sequencer.
// Owns CWP and WIM. Runs SAVE/RESTORE requests through a valid/ready
// handshake, detects window overflow/underflow, and holds any trap until it
// is acknowledged. Also produces one-hot selects for the current, caller and
// callee windows.
module window_ctrl #(
   parameter int unsigned NWIN = 8,
   parameter int unsigned CW   = $clog2(NWIN)
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            req_valid,
   input  logic            req_save,
   input  logic            req_restore,
   output logic            req_ready,
   input  logic            wr_wim,
   input  logic [NWIN-1:0] wim_in,
   input  logic            wr_cwp,
   input  logic [CW-1:0]   cwp_in,
   input  logic            trap_ack,
   output logic [CW-1:0]   cwp,
   output logic [NWIN-1:0] wim,
   output logic [NWIN-1:0] win_sel,
   output logic [NWIN-1:0] prev_sel,
   output logic [NWIN-1:0] next_sel,
   output logic            done,
   output logic            trap_valid,
   output logic [1:0]      trap_type
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      TRAP = 2'd2
   } state_t;

   localparam logic [1:0] TT_NONE     = 2'b00;
   localparam logic [1:0] TT_OVERFLOW = 2'b01;
   localparam logic [1:0] TT_UNDERFL  = 2'b10;
   localparam logic [1:0] TT_ILLEGAL  = 2'b11;

   state_t          state, state_n;
   logic            op_save, op_save_n;
   logic            op_restore, op_restore_n;
   logic [CW-1:0]   cwp_n;
   logic [NWIN-1:0] wim_n;
   logic            done_n;
   logic            trap_valid_n;
   logic [1:0]      trap_type_n;
   logic [CW-1:0]   t_save;
   logic [CW-1:0]   t_restore;
   logic [CW-1:0]   target;

   // Neighbouring windows wrap naturally through CW-bit truncation.
   assign t_save    = cwp - CW'(1);
   assign t_restore = cwp + CW'(1);
   assign target    = op_save ? t_save : t_restore;

   // Register writes block request acceptance so they never race an op.
   assign req_ready = (state == IDLE) & ~wr_wim & ~wr_cwp;

   // One-hot window selects: current, caller (cwp+1), callee (cwp-1).
   assign win_sel  = NWIN'(1) << cwp;
   assign prev_sel = NWIN'(1) << t_restore;
   assign next_sel = NWIN'(1) << t_save;

   // State and datapath registers, asynchronously cleared.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         op_save    <= 1'b0;
         op_restore <= 1'b0;
         cwp        <= '0;
         wim        <= NWIN'(2);
         done       <= 1'b0;
         trap_valid <= 1'b0;
         trap_type  <= TT_NONE;
      end else begin
         state      <= state_n;
         op_save    <= op_save_n;
         op_restore <= op_restore_n;
         cwp        <= cwp_n;
         wim        <= wim_n;
         done       <= done_n;
         trap_valid <= trap_valid_n;
         trap_type  <= trap_type_n;
      end
   end

   // Next-state logic: handshake capture, one-cycle execute, trap hold.
   // EXEC reads the registered cwp/wim, so same-cycle writes are applied
   // last and override any CWP update made by the op.
   always_comb begin
      state_n      = state;
      op_save_n    = op_save;
      op_restore_n = op_restore;
      cwp_n        = cwp;
      wim_n        = wim;
      done_n       = 1'b0;
      trap_valid_n = trap_valid;
      trap_type_n  = trap_type;

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               op_save_n    = req_save;
               op_restore_n = req_restore;
               state_n      = EXEC;
            end
         end
         EXEC: begin
            if (op_save == op_restore) begin
               trap_valid_n = 1'b1;
               trap_type_n  = TT_ILLEGAL;
               state_n      = TRAP;
            end else if (wim[target]) begin
               trap_valid_n = 1'b1;
               trap_type_n  = op_save ? TT_OVERFLOW : TT_UNDERFL;
               state_n      = TRAP;
            end else begin
               cwp_n   = target;
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         TRAP: begin
            if (trap_ack) begin
               trap_valid_n = 1'b0;
               trap_type_n  = TT_NONE;
               state_n      = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (wr_cwp) cwp_n = cwp_in;
      if (wr_wim) wim_n = wim_in;
   end

endmodule

// File: doc/window_ctrl.md
Name: window_ctrl

Overview:
- Sequencing controller for the SPARC register-window file.
- Owns the current window pointer (CWP) and the window invalid mask (WIM).
- Executes SAVE/RESTORE requests through a valid/ready handshake, with overflow/underflow trap detection and a trap hold until it is acknowledged.
- Drives one-hot window selects (current, previous, next) that feed block-enable and overlap routing of the register windows.

Parameters:
- NWIN, 8, number of register windows (power of 2, minimum 4).
- CW, 3, CWP width, equal to log2(NWIN).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  SAVE/RESTORE request valid.
- req_save  input  1  request is SAVE (decrement CWP).
- req_restore  input  1  request is RESTORE (increment CWP).
- req_ready  output  1  request accepted this cycle when req_valid=1.
- wr_wim  input  1  load WIM from wim_in.
- wim_in  input  NWIN  new WIM value.
- wr_cwp  input  1  load CWP from cwp_in.
- cwp_in  input  CW  new CWP value.
- trap_ack  input  1  trap handler acknowledge.
- cwp  output  CW  current window pointer.
- wim  output  NWIN  window invalid mask.
- win_sel  output  NWIN  one-hot of cwp.
- prev_sel  output  NWIN  one-hot of (cwp+1) mod NWIN, the caller window whose outs are our ins.
- next_sel  output  NWIN  one-hot of (cwp-1) mod NWIN, the callee window.
- done  output  1  one-cycle pulse when an operation completes without a trap.
- trap_valid  output  1  trap pending; held until acknowledged.
- trap_type  output  2  01 overflow, 10 underflow, 11 illegal request, 00 none.

Behaviour:
- Reset (asynchronous) values:
  - cwp=0, wim=1<<1 (window 1 invalid).
  - done=0, trap_valid=0, trap_type=00.
  - State IDLE.
  - win_sel/prev_sel/next_sel are combinational from cwp.
- States: IDLE, EXEC, TRAP.
- req_ready = (state==IDLE) & ~wr_wim & ~wr_cwp (combinational).
- A handshake occurs when req_valid & req_ready. The op is captured and the FSM goes to EXEC. req_valid is otherwise ignored and nothing is queued.
- EXEC (exactly one cycle), using the captured op:
  - SAVE: target t=(cwp-1) mod NWIN.
  - RESTORE: target t=(cwp+1) mod NWIN.
  - Both or neither set: illegal. Set trap_type=11, trap_valid=1, cwp unchanged, go to TRAP.
  - wim[t]=1: no CWP change. Set trap_valid=1, trap_type=01 (SAVE) or 10 (RESTORE), go to TRAP.
  - Otherwise: cwp<=t, done=1 for the next cycle only, go to IDLE.
- Latency: request accepted at edge N. cwp and done update at edge N+1, so done is high during cycle N+1. The next request can be accepted in cycle N+1.
- TRAP:
  - trap_valid and trap_type are held and req_ready=0.
  - On trap_ack: clear trap_valid, set trap_type=00, go to IDLE. The next request can be accepted the following cycle.
  - trap_ack outside TRAP is ignored.
- wr_wim / wr_cwp:
  - Take effect at the clock edge in any state, including TRAP and EXEC.
  - If asserted in the same cycle EXEC evaluates, EXEC uses the pre-write cwp/wim. If EXEC also updates cwp, wr_cwp wins.
  - Register writes have priority over request acceptance, because req_ready is forced low.
- Wrap-around: modulo NWIN arithmetic, truncated to CW bits (SAVE at cwp=0 targets NWIN-1; RESTORE at NWIN-1 targets 0).
- Reset asserted mid-EXEC or mid-TRAP aborts immediately to reset values; no done pulse is produced.

Test Plan:
1. Post-reset SAVE: cwp=7, done pulse one cycle after handshake, win_sel=0x80, prev_sel=0x01, next_sel=0x40.
2. Six further SAVEs (cwp 6→1 would hit window 1) -> cwp stops at 2, the next SAVE raises trap_valid=1, trap_type=01, cwp stays 2, req_ready=0 until trap_ack, then clears.
3. From reset, RESTORE -> target 1 invalid -> trap_type=10, cwp=0; write wim_in=0x00 then RESTORE -> cwp=1, done=1.
4. req_save=req_restore=1 -> trap_type=11, cwp unchanged; also req_valid=0 in both cases -> no state change.
5. wr_cwp with cwp_in=5 in the same cycle as req_valid -> req_ready=0, cwp=5, request accepted the next cycle; wr_cwp=3 during EXEC of a SAVE -> cwp=3.
6. Assert Reset during TRAP and during EXEC -> outputs return to reset values immediately, no done pulse, FSM in IDLE.
